seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Memory-mapped scheduler that time-multiplexes the Basys3 four-digit seven-segment display (shared segments, decimal_point, per-digit anode) among four digit values written by the AVR core over its I/O bus. It sits between the CPU I/O decode and the top-level segments/decimal_point/anode pins of avr_b3. It owns the refresh timing, inter-digit blanking, hex decode, per-digit blank and decimal point, and leading-zero suppression.

Parameters:
CLK_DIV, 25000, clk cycles per digit slot (100 MHz -> 4 kHz slot rate, 1 kHz full refresh); legal range 4..2^20.
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be < CLK_DIV.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
io_we  in  1  register write strobe, one cycle
io_addr  in  2  register select
io_wdata  in  8  write data
io_rdata  out  8  read data, registered, valid the cycle after io_addr is presented
segments  out  7  active-low segment drive, bit0=a .. bit6=g
decimal_point  out  1  active-low decimal point
anode  out  4  active-low digit enable, anode[0] = rightmost digit

Behaviour:
- Clock/reset: one clock, clk; reset synchronous, active-high, named reset.
- Register map (R/W):
  - addr0: digit1[7:4], digit0[3:0]
  - addr1: digit3[7:4], digit2[3:0]
  - addr2: blank[7:4], dp[3:0]; bit i of each applies to digit i
  - addr3: bit0 enable, bit1 lz_suppress, bits7:2 read 0, writes ignored
- Register reset values: digits 0, blank 0, dp 0, enable 1, lz_suppress 0.
- Outputs at reset: anode=4'hF, segments=7'h7F, decimal_point=1, io_rdata=0, prescaler=0, digit_idx=0.
- Prescaler counts 0..CLK_DIV-1 while enabled. At terminal count it wraps to 0 and digit_idx increments mod 4 (3 -> 0).
- Slot phase:
  - Prescaler < BLANK_CYCLES: anode=4'hF, segments=7'h7F, decimal_point=1.
  - Otherwise: anode = ~(1<<digit_idx), segments = hexdecode(digit[digit_idx]), decimal_point = ~dp[digit_idx].
- All pin outputs are registered, one cycle after the prescaler/index state that selects them.
- Digit suppression: if blank[i]=1, or digit i is leading-zero suppressed, segments=7'h7F for that slot. The anode is still driven and decimal_point still follows dp[i].
- Leading-zero suppression (lz_suppress=1): digit i (i=3..1) is suppressed when it and every higher digit are 0. Digit 0 is never suppressed.
- Hex decode, active-low gfedcba: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Writes:
  - Take effect on the clock edge with io_we.
  - They reach the pins on the next output register update: at most one cycle after the write in the active phase, regardless of slot.
  - Write and read of the same address in one cycle: io_rdata returns the old value.
- Disable (enable=0):
  - Next cycle anode=4'hF, segments=7'h7F, decimal_point=1.
  - Prescaler and digit_idx held at 0.
  - Re-enable restarts at digit 0 with a full blanking phase.
- Reset mid-slot returns everything to reset values on the next edge. The display restarts at digit 0 with a blanking phase.
- Prescaler width is $clog2(CLK_DIV). There is no combinational path from io_* to the pins.

Decomposition:
- Shared package seg7_pkg:
  - register address constants (ADDR_D10, ADDR_D32, ADDR_BLKDP, ADDR_CTRL)
  - ctrl bit positions
  - SEG_BLANK=7'h7F
  - 16-entry active-low hex glyph table
- One sub-module: seg7_hex_decode, combinational 4-bit nibble to 7-bit active-low glyph using the package table.

Test Plan:
All runs use CLK_DIV=8, BLANK_CYCLES=2.
- Reset, then 40 cycles idle -> anode cycles E,D,B,7 per 8-cycle slot, each preceded by 2 cycles of F. segments=40 in every active phase; decimal_point=1.
- Write addr0=8'h21, addr1=8'hC9 -> active-phase segments per slot: digit0 79, digit1 24, digit2 10, digit3 46.
- Write addr2=8'h25 -> digit0 and digit2 show dp=0. Digit1 shows segments=7F with anode[1]=0. Other slots unchanged.
- Write addr0=8'h05, addr1=8'h00, addr3=8'h03 -> digits 3..1 show 7F, digit0 shows 12. Then write addr1=8'h10: digit3=79, digits 2 and 1 show 40.
- Write addr3=0 mid-slot -> next cycle anode=F, segments=7F, decimal_point=1, held for 30 cycles. Write addr3=1 -> 2 blank cycles, then anode=E.
- Assert reset in the active phase of digit2 -> next cycle all outputs at reset values. Readback of addr0..3 gives 00,00,00,01 with 1-cycle io_rdata latency.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: register map,
// control bit positions and the active-low hex glyph table.
package seg7_pkg;

  localparam logic [1:0] ADDR_D10   = 2'd0;
  localparam logic [1:0] ADDR_D32   = 2'd1;
  localparam logic [1:0] ADDR_BLKDP = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_LZ_BIT = 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment patterns, bit0=a .. bit6=g, indexed by nibble value
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  assign o_glyph = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with memory-mapped digit,
// blank/dp and control registers. Each digit slot begins with a short
// all-anodes-off window to stop ghosting between digits. All pin outputs
// come straight from flops.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 25000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_we,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic [6:0] segments,
  output logic       decimal_point,
  output logic [3:0] anode
);

  localparam int            PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  logic [15:0]   r_digits;
  logic [3:0]    r_blank;
  logic [3:0]    r_dp;
  logic          r_enable;
  logic          r_lz;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [7:0]    r_rdata;
  logic [6:0]    r_seg;
  logic          r_dp_n;
  logic [3:0]    r_anode;

  logic [7:0]    w_rdata;
  logic [3:0]    w_sup;
  logic [3:0]    w_cur_digit;
  logic [6:0]    w_glyph;
  logic          w_cur_dark;

  // Register file writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= '0;
      r_blank  <= '0;
      r_dp     <= '0;
      r_enable <= 1'b1;
      r_lz     <= 1'b0;
    end else if (io_we) begin
      case (io_addr)
        ADDR_D10:   r_digits[7:0]  <= io_wdata;
        ADDR_D32:   r_digits[15:8] <= io_wdata;
        ADDR_BLKDP: begin
          r_blank <= io_wdata[7:4];
          r_dp    <= io_wdata[3:0];
        end
        ADDR_CTRL: begin
          r_enable <= io_wdata[CTRL_EN_BIT];
          r_lz     <= io_wdata[CTRL_LZ_BIT];
        end
      endcase
    end
  end

  // Readback mux (pre-write values, since the flops update on the same edge)
  always_comb begin
    w_rdata = '0;
    case (io_addr)
      ADDR_D10:   w_rdata = r_digits[7:0];
      ADDR_D32:   w_rdata = r_digits[15:8];
      ADDR_BLKDP: w_rdata = {r_blank, r_dp};
      ADDR_CTRL: begin
        w_rdata[CTRL_EN_BIT] = r_enable;
        w_rdata[CTRL_LZ_BIT] = r_lz;
      end
    endcase
  end

  // Registered read data, one cycle behind io_addr
  always_ff @(posedge clk) begin
    if (reset) r_rdata <= '0;
    else       r_rdata <= w_rdata;
  end

  // Slot prescaler and digit index; parked at zero while disabled
  always_ff @(posedge clk) begin
    if (reset || !r_enable) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_TC) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Leading-zero chain: a digit goes dark only if it and all higher digits are 0
  always_comb begin
    w_sup    = '0;
    w_sup[3] = r_lz && (r_digits[15:12] == 4'd0);
    w_sup[2] = w_sup[3] && (r_digits[11:8] == 4'd0);
    w_sup[1] = w_sup[2] && (r_digits[7:4] == 4'd0);
  end

  assign w_cur_digit = r_digits[{r_idx, 2'b00} +: 4];
  assign w_cur_dark  = r_blank[r_idx] | w_sup[r_idx];

  seg7_hex_decode u_hex_decode (
    .i_nibble (w_cur_digit),
    .o_glyph  (w_glyph)
  );

  // Pin output registers
  always_ff @(posedge clk) begin
    if (reset || !r_enable || (r_presc < BLANK_END)) begin
      r_anode <= 4'hF;
      r_seg   <= SEG_BLANK;
      r_dp_n  <= 1'b1;
    end else begin
      r_anode <= ~(4'b0001 << r_idx);
      r_seg   <= w_cur_dark ? SEG_BLANK : w_glyph;
      r_dp_n  <= ~r_dp[r_idx];
    end
  end

  assign io_rdata      = r_rdata;
  assign segments      = r_seg;
  assign decimal_point = r_dp_n;
  assign anode         = r_anode;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed, table-driven bench for seg7_scan_ctrl with CLK_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_we = 1'b0;
  logic [1:0] io_addr = 2'd0;
  logic [7:0] io_wdata = 8'h00;
  logic [7:0] io_rdata;
  logic [6:0] segments;
  logic       decimal_point;
  logic [3:0] anode;

  seg7_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_we         (io_we),
    .io_addr       (io_addr),
    .io_wdata      (io_wdata),
    .io_rdata      (io_rdata),
    .segments      (segments),
    .decimal_point (decimal_point),
    .anode         (anode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;   // edges since the slot counter was last at zero

  typedef struct packed {
    logic [2:0]  nw;
    logic [7:0]  addrs;  // write i uses addrs[2*i +: 2]
    logic [31:0] datas;  // write i uses datas[8*i +: 8]
    logic [27:0] segs;   // digit k glyph at segs[7*k +: 7]
    logic [3:0]  dpn;    // active-low dp per digit
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    if (reset) cyc = 0;
    else       cyc++;
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_we = 1'b1;
    io_addr = a;
    io_wdata = d;
    step();
    io_we = 1'b0;
  endtask

  task automatic check_slot(input vec_t v, input string tag);
    int p, k;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    p = (cyc - 1) % 8;
    k = ((cyc - 1) / 8) % 4;
    if (p < 2) begin
      ea = 4'hF; es = 7'h7F; ed = 1'b1;
    end else begin
      ea = ~(4'b0001 << k);
      es = v.segs[7*k +: 7];
      ed = v.dpn[k];
    end
    cmp({tag, " anode"},   {4'b0, anode},         {4'b0, ea});
    cmp({tag, " segments"}, {1'b0, segments},     {1'b0, es});
    cmp({tag, " dp"},       {7'b0, decimal_point}, {7'b0, ed});
  endtask

  task automatic check_dark(input string tag);
    cmp({tag, " anode"},    {4'b0, anode},          8'h0F);
    cmp({tag, " segments"}, {1'b0, segments},       8'h7F);
    cmp({tag, " dp"},       {7'b0, decimal_point},  8'h01);
  endtask

  initial begin
    logic [7:0] rb_exp [4];
    bit found;

    vecs[0] = '{nw: 3'd0, addrs: 8'h00, datas: 32'h0,
                segs: {7'h40, 7'h40, 7'h40, 7'h40}, dpn: 4'hF};
    vecs[1] = '{nw: 3'd2, addrs: {2'd0, 2'd0, 2'd1, 2'd0}, datas: {8'h00, 8'h00, 8'hC9, 8'h21},
                segs: {7'h46, 7'h10, 7'h24, 7'h79}, dpn: 4'hF};
    vecs[2] = '{nw: 3'd1, addrs: {2'd0, 2'd0, 2'd0, 2'd2}, datas: {8'h00, 8'h00, 8'h00, 8'h25},
                segs: {7'h46, 7'h10, 7'h7F, 7'h79}, dpn: 4'b1010};
    vecs[3] = '{nw: 3'd4, addrs: {2'd3, 2'd2, 2'd1, 2'd0}, datas: {8'h03, 8'h00, 8'h00, 8'h05},
                segs: {7'h7F, 7'h7F, 7'h7F, 7'h12}, dpn: 4'hF};
    vecs[4] = '{nw: 3'd1, addrs: {2'd0, 2'd0, 2'd0, 2'd1}, datas: {8'h00, 8'h00, 8'h00, 8'h10},
                segs: {7'h79, 7'h40, 7'h40, 7'h12}, dpn: 4'hF};
    vecs[5] = '{nw: 3'd4, addrs: {2'd3, 2'd2, 2'd1, 2'd0}, datas: {8'h01, 8'h8A, 8'hAB, 8'hEF},
                segs: {7'h7F, 7'h03, 7'h06, 7'h0E}, dpn: 4'b0101};
    rb_exp = '{8'h00, 8'h00, 8'h00, 8'h01};

    // Reset values
    reset = 1'b1;
    step();
    step();
    check_dark("reset");
    cmp("reset rdata", io_rdata, 8'h00);
    reset = 1'b0;

    // Idle scan after reset
    for (int i = 0; i < 40; i++) begin
      step();
      check_slot(vecs[0], "idle");
    end

    // Register patterns, each checked over a full 4-slot refresh
    for (int n = 1; n < 6; n++) begin
      for (int i = 0; i < int'(vecs[n].nw); i++)
        wr(vecs[n].addrs[2*i +: 2], vecs[n].datas[8*i +: 8]);
      step();
      for (int i = 0; i < 32; i++) begin
        check_slot(vecs[n], $sformatf("vec%0d", n));
        step();
      end
    end

    // Disable: dark on the next update and held
    wr(2'd3, 8'h00);
    step();
    for (int i = 0; i < 30; i++) begin
      check_dark("disabled");
      step();
    end

    // Re-enable: restart at digit 0 with a full blanking window
    wr(2'd3, 8'h01);
    check_dark("reenable edge");
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      check_slot(vecs[5], "reenable");
    end

    // Write and read same address in one cycle returns the old value
    io_we = 1'b1; io_addr = 2'd0; io_wdata = 8'h5A;
    step();
    io_we = 1'b0;
    cmp("rw same cycle old", io_rdata, 8'hEF);
    step();
    cmp("rw next cycle new", io_rdata, 8'h5A);

    // Reach the active phase of digit 2, then reset
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (cyc >= 1 && ((cyc - 1) % 8) >= 2 && (((cyc - 1) / 8) % 4) == 2) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL digit2 search: actual timeout expected active digit2");
    end
    cmp("digit2 anode", {4'b0, anode}, 8'h0B);
    reset = 1'b1;
    step();
    check_dark("midslot reset");
    cmp("midslot reset rdata", io_rdata, 8'h00);
    reset = 1'b0;

    // Readback of reset values, display restarting alongside
    for (int a = 0; a < 4; a++) begin
      io_addr = 2'(a);
      step();
      cmp($sformatf("readback addr%0d", a), io_rdata, rb_exp[a]);
      check_slot(vecs[0], "post reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
